// File: rtl/pc_seq_pkg.sv
// Shared types for the program sequencer: sequencer state and the
// priority-ordered per-cycle action.
package pc_seq_pkg;

    localparam int DEF_ADDR_W      = 5;
    localparam int DEF_STACK_DEPTH = 4;
    localparam int DEF_RESET_ADDR  = 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } seq_state_t;

    typedef enum logic [2:0] {
        ACT_HALT = 3'd0,
        ACT_RET  = 3'd1,
        ACT_CALL = 3'd2,
        ACT_JMP  = 3'd3,
        ACT_INC  = 3'd4,
        ACT_HOLD = 3'd5
    } seq_action_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return stack (LIFO). dout is the current top entry.
// The caller guarantees it never pushes when full or pops when empty.
module pc_ret_stack import pc_seq_pkg::*; #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  din,
    output logic [ADDR_W-1:0]                  dout,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(STACK_DEPTH+1);

    logic [ADDR_W-1:0] mem_r [STACK_DEPTH];
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] dout_s;

    // Entry storage and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (push && (count_r == CNT_W'(i))) begin
                    mem_r[i] <= din;
                end
            end
            if (push && !pop) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop && !push) begin
                count_r <= count_r - CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Top-of-stack select; reads zero while empty.
    always_comb begin
        dout_s = {ADDR_W{1'b0}};
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (count_r == CNT_W'(i + 1)) begin
                dout_s = mem_r[i];
            end else begin
                dout_s = dout_s;
            end
        end
    end

    assign dout  = dout_s;
    assign count = count_r;

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: instruction address register with increment, jumps,
// call/return through a hardware stack, halt and a sticky fault state.
module pc_sequencer import pc_seq_pkg::*; #(
    parameter int          ADDR_W      = DEF_ADDR_W,
    parameter int          STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int unsigned RESET_ADDR  = DEF_RESET_ADDR
) (
    input  logic                               clk,
    input  logic                               Reset,
    input  logic                               En,
    input  logic                               Jmp,
    input  logic                               JmpC,
    input  logic                               JmpZ,
    input  logic                               Call,
    input  logic                               Ret,
    input  logic                               Halt,
    input  logic [ADDR_W-1:0]                  Target,
    input  logic                               CY,
    input  logic                               Z,
    output logic [ADDR_W-1:0]                  addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   SP,
    output logic                               Halted,
    output logic                               Fault
);

    localparam int SP_W = $clog2(STACK_DEPTH+1);

    seq_state_t        state_r, state_nxt_s;
    seq_action_t       action_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s, stack_top_s;
    logic [SP_W-1:0]   sp_s;
    logic              push_s, pop_s, halted_r, fault_r;

    // Priority decode of the strobes into a single action for this cycle.
    always_comb begin
        action_s = ACT_HOLD;
        if ((state_r != RUN) || !En) begin
            action_s = ACT_HOLD;
        end else if (Halt) begin
            action_s = ACT_HALT;
        end else if (Ret) begin
            action_s = ACT_RET;
        end else if (Call) begin
            action_s = ACT_CALL;
        end else if (Jmp || (JmpC && CY) || (JmpZ && Z)) begin
            action_s = ACT_JMP;
        end else begin
            action_s = ACT_INC;
        end
    end

    // Next state, next address and stack control for the chosen action.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        case (action_s)
            ACT_HALT: state_nxt_s = HALT;
            ACT_RET: begin
                if (sp_s == {SP_W{1'b0}}) begin
                    state_nxt_s = FAULT;
                end else begin
                    addr_nxt_s = stack_top_s;
                    pop_s      = 1'b1;
                end
            end
            ACT_CALL: begin
                if (sp_s == SP_W'(STACK_DEPTH)) begin
                    state_nxt_s = FAULT;
                end else begin
                    addr_nxt_s = Target;
                    push_s     = 1'b1;
                end
            end
            ACT_JMP:  addr_nxt_s = Target;
            ACT_INC:  addr_nxt_s = addr_r + ADDR_W'(1);
            ACT_HOLD: addr_nxt_s = addr_r;
            default:  state_nxt_s = FAULT;
        endcase
    end

    // State, address and registered status decodes.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r  <= RUN;
            addr_r   <= ADDR_W'(RESET_ADDR);
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            addr_r   <= addr_nxt_s;
            halted_r <= (state_nxt_s == HALT);
            fault_r  <= (state_nxt_s == FAULT);
        end
    end

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (Reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (addr_r + ADDR_W'(1)),
        .dout  (stack_top_s),
        .count (sp_s)
    );

    assign addr   = addr_r;
    assign SP     = sp_s;
    assign Halted = halted_r;
    assign Fault  = fault_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// strobes checked against an abstract model (integer address, queue stack).
module tb_pc_sequencer;

    localparam int AW = 5;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          Reset = 1'b0, En = 1'b0, Jmp = 1'b0, JmpC = 1'b0, JmpZ = 1'b0;
    logic          Call = 1'b0, Ret = 1'b0, Halt = 1'b0, CY = 1'b0, Z = 1'b0;
    logic [AW-1:0] Target = '0;
    logic [AW-1:0] addr;
    logic [2:0]    SP;
    logic          Halted, Fault;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0=run, 1=halted, 2=faulted
    int m_addr  = 0;
    int m_state = 0;
    int m_stack[$];

    pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_ADDR(0)) dut (
        .clk(clk), .Reset(Reset), .En(En), .Jmp(Jmp), .JmpC(JmpC), .JmpZ(JmpZ),
        .Call(Call), .Ret(Ret), .Halt(Halt), .Target(Target), .CY(CY), .Z(Z),
        .addr(addr), .SP(SP), .Halted(Halted), .Fault(Fault)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, settle 1 time unit after the edge.
    task automatic step(input bit rst, input bit en, input bit halt, input bit ret,
                        input bit call, input bit jmp, input bit jmpc, input bit jmpz,
                        input bit cy, input bit z, input int tgt);
        Reset = rst; En = en; Halt = halt; Ret = ret; Call = call; Jmp = jmp;
        JmpC = jmpc; JmpZ = jmpz; CY = cy; Z = z; Target = AW'(tgt);
        @(posedge clk);
        if (rst) begin
            m_addr = 0; m_state = 0; m_stack.delete();
        end else if (m_state == 0 && en) begin
            if (halt) m_state = 1;
            else if (ret) begin
                if (m_stack.size() == 0) m_state = 2;
                else m_addr = m_stack.pop_back();
            end else if (call) begin
                if (m_stack.size() == SD) m_state = 2;
                else begin
                    m_stack.push_back((m_addr + 1) % 32);
                    m_addr = tgt;
                end
            end else if (jmp || (jmpc && cy) || (jmpz && z)) m_addr = tgt;
            else m_addr = (m_addr + 1) % 32;
        end
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_inc(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (addr !== 5'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", addr); end
        n_cmp++; if (SP !== 3'd0) begin n_err++; $display("FAIL reset_sp got %0d want 0", SP); end
        n_cmp++; if ({Halted, Fault} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {Halted, Fault}); end
    endtask

    task automatic test_increment();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0, 0, 0, 0, 0, 0, $urandom_range(1), $urandom_range(1), $urandom_range(31));
            n_cmp++;
            if (addr !== AW'((i + 1) % 32) || SP !== 3'd0 || Halted !== 1'b0 || Fault !== 1'b0) begin
                n_err++;
                $display("FAIL inc[%0d] got addr=%0d sp=%0d h=%b f=%b want addr=%0d sp=0 h=0 f=0",
                         i, addr, SP, Halted, Fault, (i + 1) % 32);
            end
        end
    endtask

    task automatic test_cond_jump();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            run_inc(3);
            // flag clear: falls through to increment
            step(0, 1, 0, 0, 0, 0, k == 0, k == 1, 0, 0, 10);
            n_cmp++; if (addr !== 5'd4) begin n_err++; $display("FAIL cjump_nt[%0d] got %0d want 4", k, addr); end
            step(0, 1, 0, 0, 0, 0, k == 0, k == 1, k == 0, k == 1, 10);
            n_cmp++; if (addr !== 5'd10) begin n_err++; $display("FAIL cjump_t[%0d] got %0d want 10", k, addr); end
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        run_inc(5);
        step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 20);
        n_cmp++; if (addr !== 5'd20 || SP !== 3'd1) begin n_err++; $display("FAIL call got addr=%0d sp=%0d want 20/1", addr, SP); end
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (addr !== 5'd6 || SP !== 3'd0) begin n_err++; $display("FAIL ret got addr=%0d sp=%0d want 6/0", addr, SP); end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, $urandom_range(31));
            n_cmp++;
            if (addr !== AW'(m_addr) || SP !== 3'(m_stack.size())) begin
                n_err++; $display("FAIL nest_call[%0d] got addr=%0d sp=%0d want %0d/%0d", i, addr, SP, m_addr, m_stack.size());
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (addr !== AW'(m_addr) || SP !== 3'(m_stack.size())) begin
                n_err++; $display("FAIL nest_ret[%0d] got addr=%0d sp=%0d want %0d/%0d", i, addr, SP, m_addr, m_stack.size());
            end
        end
    endtask

    task automatic test_overflow();
        int frozen;
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 8 + i);
        frozen = m_addr;
        step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 30);
        n_cmp++;
        if (Fault !== 1'b1 || Halted !== 1'b0 || addr !== AW'(frozen) || SP !== 3'd4) begin
            n_err++; $display("FAIL overflow got f=%b h=%b addr=%0d sp=%0d want 1/0/%0d/4", Fault, Halted, addr, SP, frozen);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 17);
            n_cmp++;
            if (Fault !== 1'b1 || addr !== AW'(frozen) || SP !== 3'd4) begin
                n_err++; $display("FAIL fault_frozen[%0d] got f=%b addr=%0d sp=%0d want 1/%0d/4", i, Fault, addr, SP, frozen);
            end
        end
        do_reset();
        n_cmp++; if (addr !== 5'd0 || Fault !== 1'b0 || SP !== 3'd0) begin n_err++; $display("FAIL fault_reset got addr=%0d f=%b sp=%0d want 0/0/0", addr, Fault, SP); end
    endtask

    task automatic test_underflow_halt();
        do_reset();
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (Fault !== 1'b1 || addr !== 5'd0 || Halted !== 1'b0) begin n_err++; $display("FAIL underflow got f=%b addr=%0d h=%b want 1/0/0", Fault, addr, Halted); end
        do_reset();
        run_inc(7);
        step(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 25);
        n_cmp++;
        if (Halted !== 1'b1 || Fault !== 1'b0 || addr !== 5'd7 || SP !== 3'd0) begin
            n_err++; $display("FAIL halt_prio got h=%b f=%b addr=%0d sp=%0d want 1/0/7/0", Halted, Fault, addr, SP);
        end
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 25);
        n_cmp++; if (Halted !== 1'b1 || addr !== 5'd7) begin n_err++; $display("FAIL halt_hold got h=%b addr=%0d want 1/7", Halted, addr); end
    endtask

    task automatic test_stall();
        do_reset();
        run_inc(2);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 19);
            n_cmp++; if (addr !== 5'd2) begin n_err++; $display("FAIL stall[%0d] got %0d want 2", i, addr); end
        end
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 19);
        n_cmp++; if (addr !== 5'd0) begin n_err++; $display("FAIL reset_no_en got %0d want 0", addr); end
        run_inc(3);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        n_cmp++; if (Halted !== 1'b0 || addr !== 5'd0) begin n_err++; $display("FAIL halt_reset got h=%b addr=%0d want 0/0", Halted, addr); end
        run_inc(1);
        n_cmp++; if (addr !== 5'd1) begin n_err++; $display("FAIL run_after_reset got %0d want 1", addr); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(30) == 0, $urandom_range(6) != 0,
                 $urandom_range(40) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
                 $urandom_range(6) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                 $urandom_range(1), $urandom_range(1), $urandom_range(31));
            n_cmp++;
            if (addr !== AW'(m_addr) || SP !== 3'(m_stack.size()) ||
                Halted !== (m_state == 1) || Fault !== (m_state == 2)) begin
                n_err++;
                $display("FAIL random[%0d] got addr=%0d sp=%0d h=%b f=%b want addr=%0d sp=%0d h=%0d f=%0d",
                         i, addr, SP, Halted, Fault, m_addr, m_stack.size(), m_state == 1, m_state == 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_cond_jump();
        test_call_ret();
        test_overflow();
        test_underflow_halt();
        test_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
